// File: rtl/run_len_pkg.sv
// run_len_pkg: shared types and helpers for run_len_detector.
//   state_t    - run tracker state (IDLE: no history, RUN: history valid)
//   MODE_*     - polarity-select encodings for the mode input (2'b11 acts as BOTH)
//   sat_inc    - increment that saturates at 2^width-1 instead of wrapping
package run_len_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/run_len_detector_if.sv
// run_len_detector_if: sample/control inputs and status outputs of the run
// length detector, bundled as one interface.
//   master: drives cen, din, clr, mode, thr_x, thr_y; observes the outputs
//   slave : the detector side
interface run_len_detector_if #(parameter int CNT_W = 4);
  logic             cen;
  logic             din;
  logic             clr;
  logic [1:0]       mode;
  logic [CNT_W-1:0] thr_x;
  logic [CNT_W-1:0] thr_y;
  logic             doutx;
  logic             douty;
  logic             run_bit;
  logic [CNT_W-1:0] run_len;
  logic             run_end;
  logic [CNT_W-1:0] max_len;

  modport master (
    output cen, din, clr, mode, thr_x, thr_y,
    input  doutx, douty, run_bit, run_len, run_end, max_len
  );

  modport slave (
    input  cen, din, clr, mode, thr_x, thr_y,
    output doutx, douty, run_bit, run_len, run_end, max_len
  );
endinterface

// File: rtl/run_len_flag.sv
// run_len_flag: one threshold flag. Registers (pol_ok && thr!=0 && new_len>=thr)
// on sampling cycles; the flag drops on non-sampling cycles, on clr and on reset.
//   clk, resetn (sync, active-low), clr, cen
//   new_len - run length being written this cycle
//   thr     - threshold, 0 disables the flag
//   pol_ok  - polarity gate for the new run bit
//   dout    - registered flag
module run_len_flag #(parameter int CNT_W = 4) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             cen,
  input  logic [CNT_W-1:0] new_len,
  input  logic [CNT_W-1:0] thr,
  input  logic             pol_ok,
  output logic             dout
);

  always_ff @(posedge clk) begin
    if (!resetn || clr)
      dout <= 1'b0;
    else if (!cen)
      dout <= 1'b0;
    else
      dout <= pol_ok && (thr != '0) && (new_len >= thr);
  end

endmodule

// File: rtl/run_len_detector.sv
// run_len_detector: tracks the length of the current run of identical sampled
// bits (saturating at 2^CNT_W-1) and flags runs reaching thresholds X and Y.
//   clk    - clock
//   resetn - synchronous, active-low reset (priority over clr)
//   bus    - run_len_detector_if.slave: cen/din/clr/mode/thr_x/thr_y in,
//            doutx/douty/run_bit/run_len/run_end/max_len out
// Optional statistics (run_end pulse, max_len) are built only when the macro
// RUN_LEN_STATS_EN is defined; otherwise both outputs are tied to 0.
module run_len_detector
  import run_len_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  run_len_detector_if.slave     bus
);

  state_t           state_q, state_d;
  logic             run_bit_q, run_bit_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             pol_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      run_bit_q <= 1'b0;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_bit_q <= run_bit_d;
      run_len_q <= run_len_d;
    end
  end

  // clr beats cen: the sample on a clr cycle is dropped. cen=0 holds
  // everything, so sampling gaps never break a run.
  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit_q;
    run_len_d = run_len_q;
    if (bus.clr) begin
      state_d   = IDLE;
      run_bit_d = 1'b0;
      run_len_d = '0;
    end else if (bus.cen) begin
      case (state_q)
        IDLE: begin
          state_d   = RUN;
          run_bit_d = bus.din;
          run_len_d = CNT_W'(1);
        end
        RUN: begin
          if (bus.din == run_bit_q) begin
            run_len_d = CNT_W'(sat_inc(32'(run_len_q), CNT_W));
          end else begin
            run_bit_d = bus.din;
            run_len_d = CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Polarity gate looks at the bit of the run being written, not the old one.
  always_comb begin
    case (bus.mode)
      MODE_ONES:  pol_ok = run_bit_d;
      MODE_ZEROS: pol_ok = ~run_bit_d;
      default:    pol_ok = 1'b1;
    endcase
  end

  logic [1:0][CNT_W-1:0] thr;
  logic [1:0]            flag;

  assign thr = {bus.thr_y, bus.thr_x};

  for (genvar i = 0; i < 2; i++) begin : g_flag
    run_len_flag #(.CNT_W(CNT_W)) u_flag (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (bus.clr),
      .cen     (bus.cen),
      .new_len (run_len_d),
      .thr     (thr[i]),
      .pol_ok  (pol_ok),
      .dout    (flag[i])
    );
  end

  assign bus.doutx   = flag[0];
  assign bus.douty   = flag[1];
  assign bus.run_bit = run_bit_q;
  assign bus.run_len = run_len_q;

`ifdef RUN_LEN_STATS_EN
  logic             brk;
  logic             run_end_q;
  logic [CNT_W-1:0] max_len_q;

  // A break is an opposite bit sampled while a run exists; clr never counts.
  assign brk = (state_q == RUN) && bus.cen && !bus.clr && (bus.din != run_bit_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_end_q <= 1'b0;
      max_len_q <= '0;
    end else begin
      run_end_q <= brk;
      if (brk && (run_len_q > max_len_q))
        max_len_q <= run_len_q;
    end
  end

  assign bus.run_end = run_end_q;
  assign bus.max_len = max_len_q;
`else
  assign bus.run_end = 1'b0;
  assign bus.max_len = '0;
`endif

endmodule

// File: doc/run_len_detector.md
Name: run_len_detector

Overview:
- Parametrised successor to the team's fixed two/three-bit consecutive-value Mealy detector.
- Tracks the length of the current run of identical sampled bits on a serial input, with a saturating counter.
- Flags runs that reach two runtime-programmable thresholds, with per-polarity mode selection, valid-gated sampling and a synchronous clear.
- Sits on serial bit streams (line coding checks, stuck-bit detection) upstream of the status/interrupt logic.

Parameters:
CNT_W, 4, width of run-length counter and thresholds; run length saturates at 2^CNT_W-1

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
cen  input  1  sample enable; din is sampled only when cen=1
din  input  1  serial data bit
clr  input  1  synchronous clear of run history
mode  input  2  00/11 both polarities, 01 runs of ones only, 10 runs of zeros only
thr_x  input  CNT_W  threshold X; 0 disables doutx
thr_y  input  CNT_W  threshold Y; 0 disables douty
doutx  output  1  run length >= thr_x on the last sample
douty  output  1  run length >= thr_y on the last sample
run_bit  output  1  polarity of current run
run_len  output  CNT_W  current run length
run_end  output  1  optional-feature pulse (see below)
max_len  output  CNT_W  optional-feature longest run (see below)

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; run_len=0, run_bit=0, doutx=0, douty=0, run_end=0, max_len=0.
- FSM states:
  - IDLE: no history.
  - RUN: history valid.
- IDLE, cen=1: go to RUN; run_bit<=din; run_len<=1.
- RUN, cen=1, din==run_bit: run_len<=min(run_len+1, 2^CNT_W-1). Saturation holds the value; it does not wrap.
- RUN, cen=1, din!=run_bit: run_bit<=din; run_len<=1.
- cen=0: state, run_bit and run_len hold; doutx<=0, douty<=0. Gaps do not break a run.
- Flag computation:
  - new_len is the run_len value being written this cycle.
  - pol_ok = mode==01 ? new run_bit==1 : mode==10 ? new run_bit==0 : 1.
  - On a cen=1 cycle: doutx <= pol_ok && thr_x!=0 && new_len>=thr_x; douty likewise with thr_y.
- Latency: flags and run_len are registered and valid one cycle after the sampling edge. There is no combinational din-to-output path.
- thr_x, thr_y and mode are evaluated at each sampling edge. A change affects the next sample only and is never retroactive.
- Saturation: with thr = 2^CNT_W-1, the flag asserts once saturated and stays asserted for every further matching sample.
- clr=1 (resetn=1): return to IDLE; run_len=0, run_bit=0, doutx=0, douty=0, run_end=0. max_len is preserved.
- clr and cen together: clr wins and the sample is discarded.
- Reset mid-run: identical to power-on reset. resetn has priority over clr.

Optional Feature:
- Macro: RUN_LEN_STATS_EN.
- Defined:
  - run_end pulses for one cycle on the edge after a run is broken by an opposite bit (cen=1, din!=run_bit, state RUN).
  - max_len <= max(max_len, run_len) on that same break edge.
  - max_len clears only on resetn.
  - clr does not generate run_end.
- Undefined: run_end and max_len are tied to 0 and no statistics logic is built.

Decomposition:
- Package run_len_pkg holds:
  - state_t enum {IDLE, RUN};
  - mode encodings MODE_BOTH=2'b00, MODE_ONES=2'b01, MODE_ZEROS=2'b10;
  - function sat_inc(value, width).
- Sub-module run_len_flag (one instance per threshold): comparator plus polarity gate plus output register, taking new_len, thr, pol_ok and cen. Instantiated twice, for X and Y.

Test Plan:
- Basic run (CNT_W=4, thr_x=2, thr_y=3, mode=00, cen=1): din 0,0,0,1,1.
  - run_len 1,2,3,1,2.
  - doutx 0,1,1,0,1.
  - douty 0,0,1,0,0.
- Saturation: 20 ones with thr_y=15 → run_len reaches 15 at sample 15 and holds; douty=1 from sample 15 through 20.
- cen gap: samples 1,1, then cen=0 for 3 cycles, then 1.
  - doutx/douty =0 during the gap.
  - run_len holds at 2 during the gap.
  - After the final sample, run_len=3 and douty=1 with thr_y=3.
- Polarity mode: mode=01 with din 0,0,0,0 → doutx=douty=0 while run_len=4. Then 1,1,1 → douty=1 on the third one.
- clr/reset: clr during a run of length 5 with simultaneous cen=1 → next cycle run_len=0, flags 0. The following sample gives run_len=1. resetn=0 mid-run gives all outputs 0.
- RUN_LEN_STATS_EN: din 1×6, 0×3, 1 → run_end pulses after the first and second breaks. max_len=6 after the first, stays 6 after the second. No run_end on clr.
